// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and opcode constants for the instruction fetch unit.
// Contents: default PC/instruction widths, opcode field position, the
// opcodes the fetch path cares about, and an opcode extraction helper.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] OPC_HALT = 4'b0111;
    localparam logic [3:0] OPC_JUMP = 4'b0010;
    localparam logic [3:0] OPC_BEQ  = 4'b1000;

    function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding {pc, instr} prefetch entries.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, wdata     write one entry at the tail
//   pop             remove the head entry
//   flush           discard every entry (wins over push/pop)
//   rdata           head entry (stale when empty)
//   count           occupied entries
module fetch_queue #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        if (push && !flush)
            mem_d[wr_q] = wdata;
        wr_d  = flush ? '0 : push ? wr_q + 1'b1 : wr_q;
        rd_d  = flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
        cnt_d = flush ? '0 : cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;

    // The issue credit in the parent must make this unreachable.
    assert property (@(posedge clk) disable iff (!reset) !(push && !flush && cnt_q == FULL));

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, instruction memory requests and prefetch queue
// feeding the control unit over a valid/ready handshake.
// Optional feature: INSTR_FETCH_HALT_DETECT_EN stops fetch on a halt opcode.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   imem_req, imem_addr         read request to instruction memory
//   imem_rdata                  read data, one cycle after imem_req
//   instr, instr_pc             queue head instruction and its address
//   instr_valid, instr_ready    head handshake with the control unit
//   redirect, redirect_pc       taken jump/branch: flush and refetch
//   q_count                     occupied queue entries
//   halted                      fetch stopped on a halt opcode
module instr_fetch_unit #(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic [INSTR_W-1:0]       instr,
    output logic [PC_W-1:0]          instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     halted
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, infl_pc_q, infl_pc_d;
    logic            inflight_q, inflight_d, drop_q, drop_d, halted_q, halted_d;
    logic            issue, push, pop, halt_hit;
    logic [CW-1:0]   credit;

    always_comb begin
        // Occupied plus in-flight slots: never request more than the queue holds.
        credit = q_count + {{(CW-1){1'b0}}, inflight_q};
        issue  = reset && !halted_q && !redirect && credit < CW'(DEPTH);
        // A word returning in a redirect cycle is discarded by the flush itself;
        // no request is issued then, so nothing lands after the redirect.
        push   = inflight_q && !drop_q && !redirect;
        pop    = instr_valid && instr_ready;
`ifdef INSTR_FETCH_HALT_DETECT_EN
        halt_hit = push && opcode(imem_rdata) == OPC_HALT;
`else
        halt_hit = 1'b0;
`endif
        fetch_pc_d = redirect ? redirect_pc : issue ? fetch_pc_q + 1'b1 : fetch_pc_q;
        inflight_d = issue;
        infl_pc_d  = issue ? fetch_pc_q : infl_pc_q;
        // The word requested alongside the halt push is the only one still in flight.
        drop_d     = redirect ? 1'b0 : (halt_hit && issue) ? 1'b1 : inflight_q ? 1'b0 : drop_q;
        halted_d   = redirect ? 1'b0 : halt_hit ? 1'b1 : halted_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= '0;
            infl_pc_q  <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_pc_q  <= infl_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
        end
    end

    fetch_queue #(
        .W     (PC_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({infl_pc_q, imem_rdata}),
        .pop   (pop),
        .flush (redirect),
        .rdata ({instr_pc, instr}),
        .count (q_count)
    );

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = q_count != '0;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, imem_req, instr_valid, instr_ready, redirect, halted;
    logic [7:0]  imem_addr, instr_pc, redirect_pc;
    logic [15:0] imem_rdata, instr;
    logic [2:0]  q_count;

    logic [15:0] mem [256];
    logic [23:0] exp_q [$];
    logic [23:0] e;
    logic [7:0]  next_pc;
    int          tests = 0, fails = 0, pops = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .q_count     (q_count),
        .halted      (halted)
    );

    // Synchronous memory; garbage on idle cycles exposes spurious pushes.
    always @(posedge clk) imem_rdata <= imem_req ? mem[imem_addr] : 16'($urandom);

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, x);
        end
    endtask

    // Reference: the consumer sees consecutive addresses from the last target.
    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back({next_pc, mem[next_pc]});
            next_pc++;
        end
    endtask

    task automatic cyc(input logic rdy, input logic rd, input logic [7:0] tgt);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = tgt;
        @(negedge clk);
        #1;
        if (rd) begin
            exp_q.delete();
            next_pc = tgt;
        end
        top_up();
        @(posedge clk);
        #1;
    endtask

    task automatic redir_lat(input logic rdy, input logic [7:0] t);
        cyc(rdy, 1'b1, t);
        chk("redir_valid_c1", instr_valid, 0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("redir_valid_c2", instr_valid, 0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("redir_valid_c3", instr_valid, 1);
        chk("redir_target_pc", instr_pc, t);
    endtask

    initial forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
            chk("q_count_bound", q_count <= 3'd4, 1);
            chk("halted_low", halted, 0);
            if (instr_valid && instr_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_underflow: got pc %0h with nothing expected", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    if ({instr_pc, instr} !== e) begin
                        fails++;
                        $display("FAIL deliver: got pc %0h instr %0h expected pc %0h instr %0h",
                                 instr_pc, instr, e[23:16], e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:12] == 4'h7) mem[i][15:12] = 4'h4;
        end
        reset = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_halted", halted, 0);
        next_pc = 8'h00;
        top_up();
        reset = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        chk("first_valid_c1", instr_valid, 0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("first_valid_c2", instr_valid, 1);
        chk("first_pc", instr_pc, 0);
        repeat (20) cyc(1'b1, 1'b0, 8'h00);
        repeat (10) cyc(1'b0, 1'b0, 8'h00);
        chk("stall_q_count", q_count, 4);
        chk("stall_imem_req", imem_req, 0);
        repeat (10) cyc(1'b1, 1'b0, 8'h00);
        repeat (6) cyc(1'b0, 1'b0, 8'h00);
        redir_lat(1'b0, 8'h20);
        redir_lat(1'b1, 8'hFE);
        repeat (6) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h03);
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
        chk("head_pc3", instr_pc, 8'h03);
        redir_lat(1'b1, 8'h77);
        repeat (4) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h10);
        redir_lat(1'b1, 8'h40);
        repeat (1500) cyc($urandom % 4 != 0, $urandom % 20 == 0, 8'($urandom));
        instr_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_q_count", q_count, 0);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_imem_req", imem_req, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        next_pc = 8'h00;
        top_up();
        reset = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        chk("post_rst_valid_c1", instr_valid, 0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("post_rst_valid_c2", instr_valid, 1);
        chk("post_rst_pc", instr_pc, 0);
        repeat (5) cyc(1'b1, 1'b0, 8'h00);
        chk("progress", pops > 500, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
